// File: rtl/seq_program_loader.sv
// Host command loader for a column of instruction-memory sequencers: command FIFO,
// instr_load chain serialiser and call/ret launch engine. `SEQ_LOADER_RUNTIME_EN adds last_runtime.
module seq_program_loader #(
    parameter int unsigned INSTR_DATA_WIDTH = 32,
    parameter int unsigned INSTR_ADDR_WIDTH = 6,
    parameter int unsigned INSTR_HOPS_WIDTH = 4,
    parameter int unsigned NUM_SEQ          = 4,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [INSTR_HOPS_WIDTH-1:0] cmd_hops,
    input  logic [INSTR_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [INSTR_DATA_WIDTH-1:0] cmd_data,
    output logic [INSTR_DATA_WIDTH-1:0] instr_load_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_load_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_load_hops_out,
    output logic                        instr_load_en_out,
    output logic [NUM_SEQ-1:0]          call,
    input  logic [NUM_SEQ-1:0]          ret,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout
`ifdef SEQ_LOADER_RUNTIME_EN
    ,
    output logic [31:0]                 last_runtime
`endif
);

    localparam int unsigned DW   = INSTR_DATA_WIDTH;
    localparam int unsigned AW   = INSTR_ADDR_WIDTH;
    localparam int unsigned HW   = INSTR_HOPS_WIDTH;
    localparam int unsigned EW   = 1 + HW + AW + DW;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTRW = PW + 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [PTRW-1:0] PTR_ONE   = PTRW'(1);
    localparam logic [TW-1:0]   TIMER_ONE = TW'(1);
    localparam logic [TW-1:0]   TIMER_INI = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALL,
        ST_WAIT_RET
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full, push, pop;

    logic [EW-1:0]      head;
    logic               head_op;
    logic [HW-1:0]      head_hops;
    logic [AW-1:0]      head_addr;
    logic [DW-1:0]      head_data;
    logic [NUM_SEQ-1:0] head_mask;

    logic [NUM_SEQ-1:0] mask_q, mask_d;
    logic [NUM_SEQ-1:0] seen_q, seen_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_SEQ-1:0] call_d;
    logic               done_d, timeout_d;
    logic               ld_en_d;
    logic [DW-1:0]      ld_data_d;
    logic [AW-1:0]      ld_addr_d;
    logic [HW-1:0]      ld_hops_d;

    // Full/empty come from registered pointers only, so a push is never popped in the same cycle.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

    assign head      = fifo_mem[rd_ptr[PW-1:0]];
    assign head_op   = head[EW-1];
    assign head_hops = head[AW+DW +: HW];
    assign head_addr = head[DW +: AW];
    assign head_data = head[DW-1:0];
    assign head_mask = head_data[NUM_SEQ-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= {cmd_op, cmd_hops, cmd_addr, cmd_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        seen_d    = seen_q;
        timer_d   = timer_q;
        call_d    = '0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        ld_en_d   = 1'b0;
        ld_data_d = '0;
        ld_addr_d = '0;
        ld_hops_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!head_op) begin
                        ld_en_d   = 1'b1;
                        ld_data_d = head_data;
                        ld_addr_d = head_addr;
                        ld_hops_d = head_hops;
                    end else if (head_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mask_d  = head_mask;
                        call_d  = head_mask;
                        state_d = ST_CALL;
                    end
                end
            end
            ST_CALL: begin
                seen_d  = ret & mask_q;
                timer_d = TIMER_INI;
                state_d = ST_WAIT_RET;
            end
            ST_WAIT_RET: begin
                seen_d = seen_q | (ret & mask_q);
                if ((seen_q | (ret & mask_q)) == mask_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q - TIMER_ONE;
                    if (timer_q == TIMER_ONE) begin
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q              <= '0;
            seen_q              <= '0;
            timer_q             <= '0;
            call                <= '0;
            done                <= 1'b0;
            timeout             <= 1'b0;
            instr_load_en_out   <= 1'b0;
            instr_load_data_out <= '0;
            instr_load_addr_out <= '0;
            instr_load_hops_out <= '0;
        end else begin
            mask_q              <= mask_d;
            seen_q              <= seen_d;
            timer_q             <= timer_d;
            call                <= call_d;
            done                <= done_d;
            timeout             <= timeout_d;
            instr_load_en_out   <= ld_en_d;
            instr_load_data_out <= ld_data_d;
            instr_load_addr_out <= ld_addr_d;
            instr_load_hops_out <= ld_hops_d;
        end
    end

`ifdef SEQ_LOADER_RUNTIME_EN
    logic [31:0] run_cnt_q, run_cnt_inc;

    // run_cnt_q holds cycles already spent in CALL/WAIT_RET; +1 includes the current cycle.
    assign run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q    <= '0;
            last_runtime <= '0;
        end else begin
            if (state_q == ST_IDLE) run_cnt_q <= '0;
            else                    run_cnt_q <= run_cnt_inc;
            if (done_d) last_runtime <= (state_q == ST_IDLE) ? 32'd0 : run_cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_seq_program_loader.sv
// Directed self-checking bench for seq_program_loader (TIMEOUT_CYCLES = 8, FIFO_DEPTH = 4).
module tb_seq_program_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned HW = 4;
    localparam int unsigned NS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [HW-1:0] cmd_hops;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] instr_load_data_out;
    logic [AW-1:0] instr_load_addr_out;
    logic [HW-1:0] instr_load_hops_out;
    logic          instr_load_en_out;
    logic [NS-1:0] call;
    logic [NS-1:0] ret;
    logic          busy;
    logic          done;
    logic          timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    seq_program_loader #(
        .INSTR_DATA_WIDTH(DW),
        .INSTR_ADDR_WIDTH(AW),
        .INSTR_HOPS_WIDTH(HW),
        .NUM_SEQ(NS),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_hops(cmd_hops),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .instr_load_data_out(instr_load_data_out),
        .instr_load_addr_out(instr_load_addr_out),
        .instr_load_hops_out(instr_load_hops_out),
        .instr_load_en_out(instr_load_en_out),
        .call(call),
        .ret(ret),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    // Control outputs packed as {cmd_ready, en, call, busy, done, timeout}.
    function automatic logic [NS+4:0] ctl();
        return {cmd_ready, instr_load_en_out, call, busy, done, timeout};
    endfunction

    function automatic logic [HW+AW+DW:0] ld();
        return {instr_load_en_out, instr_load_hops_out, instr_load_addr_out, instr_load_data_out};
    endfunction

    task automatic drive_cmd(input logic op, input logic [HW-1:0] h,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_hops  = h;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_hops = '0; cmd_addr = '0; cmd_data = '0; ret = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'b0000, 3'b000})
            $display("FAIL reset_ctl: got %b exp %b", ctl(), {1'b1, 1'b0, 4'b0000, 3'b000});
        else n_pass++;
        n_checks++;
        if (ld() !== '0) $display("FAIL reset_load: got %h exp 0", ld());
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'b0000, 3'b000})
            $display("FAIL reset_release_ctl: got %b exp %b", ctl(), {1'b1, 1'b0, 4'b0000, 3'b000});
        else n_pass++;
    endtask

    task automatic test_write_stream();
        @(negedge clk);
        drive_cmd(1'b0, 4'd2, 6'd5, 32'hDEADBEEF);
        @(negedge clk);
        drive_cmd(1'b0, 4'd0, 6'd6, 32'h00000001);
        n_checks++;
        if ({instr_load_en_out, busy} !== 2'b01)
            $display("FAIL wr_no_fallthrough: got en,busy=%b exp 01", {instr_load_en_out, busy});
        else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (ld() !== {1'b1, 4'd2, 6'd5, 32'hDEADBEEF})
            $display("FAIL wr_first: got %h exp %h", ld(), {1'b1, 4'd2, 6'd5, 32'hDEADBEEF});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ld() !== {1'b1, 4'd0, 6'd6, 32'h00000001})
            $display("FAIL wr_second: got %h exp %h", ld(), {1'b1, 4'd0, 6'd6, 32'h00000001});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ld(), busy} !== '0) $display("FAIL wr_idle: got load=%h busy=%b exp 0", ld(), busy);
        else n_pass++;
    endtask

    task automatic test_launch_zero();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({call, done, timeout} !== 6'b0000_10)
            $display("FAIL launch_zero_done: got call,done,to=%b exp 000010", {call, done, timeout});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL launch_zero_after: got done,busy=%b exp 00", {done, busy});
        else n_pass++;
    endtask

    task automatic test_launch_single();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({call, busy} !== 5'b0001_1) $display("FAIL single_call: got call,busy=%b exp 00011", {call, busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({call, done, busy} !== 6'b0000_01)
            $display("FAIL single_call_width: got call,done,busy=%b exp 000001", {call, done, busy});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        ret = 4'b0001;
        n_checks++;
        if (done !== 1'b0) $display("FAIL single_early_done: got %b exp 0", done);
        else n_pass++;
        @(negedge clk);
        ret = '0;
        n_checks++;
        if ({done, timeout, busy} !== 3'b100)
            $display("FAIL single_done: got done,to,busy=%b exp 100", {done, timeout, busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL single_done_pulse: got %b exp 0", done);
        else n_pass++;
    endtask

    task automatic test_launch_multi();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h5);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (call !== 4'b0101) $display("FAIL multi_call: got %b exp 0101", call);
        else n_pass++;
        for (int n = 3; n <= 11; n++) begin
            @(negedge clk);
            ret = '0;
            if (n == 4) ret = 4'b0001;
            if (n == 6) ret = 4'b0010;
            if (n == 9) ret = 4'b0100;
            if (n == 7 || n == 9) begin
                n_checks++;
                if ({done, busy} !== 2'b01)
                    $display("FAIL multi_wait_n%0d: got done,busy=%b exp 01", n, {done, busy});
                else n_pass++;
            end
            if (n == 10) begin
                n_checks++;
                if ({done, timeout} !== 2'b10)
                    $display("FAIL multi_done: got done,to=%b exp 10", {done, timeout});
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h2);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 2; n <= 12; n++) begin
            @(negedge clk);
            if (n == 2) begin
                n_checks++;
                if (call !== 4'b0010) $display("FAIL to_call: got %b exp 0010", call);
                else n_pass++;
            end
            if (n == 10) begin
                n_checks++;
                if ({done, timeout, busy} !== 3'b001)
                    $display("FAIL to_early: got done,to,busy=%b exp 001", {done, timeout, busy});
                else n_pass++;
            end
            if (n == 11) begin
                n_checks++;
                if ({done, timeout, busy} !== 3'b110)
                    $display("FAIL to_pulse: got done,to,busy=%b exp 110", {done, timeout, busy});
                else n_pass++;
            end
            if (n == 12) begin
                n_checks++;
                if ({done, timeout} !== 2'b00) $display("FAIL to_pulse_len: got done,to=%b exp 00", {done, timeout});
                else n_pass++;
            end
        end
    endtask

    task automatic test_fifo_backpressure();
        int unsigned widx = 0;
        logic rdy_prev;
        logic [HW+AW+DW:0] exp_ld;
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h1);
        rdy_prev = cmd_ready;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (cmd_valid && rdy_prev && !cmd_op) widx++;
            if (widx < 6) drive_cmd(1'b0, 4'(widx + 1), 6'(widx + 10), 32'hA5A50000 + 32'(widx));
            else cmd_valid = 1'b0;
            rdy_prev = cmd_ready;
            ret = (n == 8) ? 4'b0001 : 4'b0000;
            if (n == 2) begin
                n_checks++;
                if (call !== 4'b0001) $display("FAIL bp_call: got %b exp 0001", call);
                else n_pass++;
            end
            if (n >= 2 && n <= 9) begin
                n_checks++;
                if (instr_load_en_out !== 1'b0) $display("FAIL bp_no_write_n%0d: got en=1 exp 0", n);
                else n_pass++;
            end
            if (n == 4) begin
                n_checks++;
                if (cmd_ready !== 1'b1) $display("FAIL bp_ready_3: got %b exp 1", cmd_ready);
                else n_pass++;
            end
            if (n == 5 || n == 9) begin
                n_checks++;
                if ({cmd_ready, widx} !== {1'b0, 32'd4})
                    $display("FAIL bp_full_n%0d: got ready=%b accepts=%0d exp ready=0 accepts=4", n, cmd_ready, widx);
                else n_pass++;
            end
            if (n == 8 || n == 9) begin
                n_checks++;
                if (done !== (n == 9)) $display("FAIL bp_done_n%0d: got %b exp %b", n, done, n == 9);
                else n_pass++;
            end
            if (n >= 10 && n <= 15) begin
                exp_ld = {1'b1, 4'(n - 9), 6'(n), 32'hA5A50000 + 32'(n - 10)};
                n_checks++;
                if (ld() !== exp_ld) $display("FAIL bp_stream_n%0d: got %h exp %h", n, ld(), exp_ld);
                else n_pass++;
            end
            if (n == 16) begin
                n_checks++;
                if ({instr_load_en_out, busy, widx} !== {2'b00, 32'd6})
                    $display("FAIL bp_end: got en,busy=%b accepts=%0d exp 00 6", {instr_load_en_out, busy}, widx);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            drive_cmd(1'b0, 4'(n), 6'(n + 20), 32'hC0DE0000 + 32'(n));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) $display("FAIL rst_pre_full: got ready,busy=%b exp 01", {cmd_ready, busy});
        else n_pass++;
        rst_n = 1'b0;
        ret = 4'b0001;
        #1;
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'b0000, 3'b000})
            $display("FAIL rst_async: got %b exp %b", ctl(), {1'b1, 1'b0, 4'b0000, 3'b000});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ret = '0;
        for (int n = 7; n <= 8; n++) begin
            @(negedge clk);
            n_checks++;
            if ({instr_load_en_out, done, busy, cmd_ready} !== 4'b0001)
                $display("FAIL rst_after_n%0d: got en,done,busy,ready=%b exp 0001", n,
                         {instr_load_en_out, done, busy, cmd_ready});
            else n_pass++;
        end
        drive_cmd(1'b1, 4'd0, 6'd0, 32'h4);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (call !== 4'b0100) $display("FAIL rst_relaunch_call: got %b exp 0100", call);
        else n_pass++;
        @(negedge clk);
        ret = 4'b0100;
        @(negedge clk);
        ret = '0;
        n_checks++;
        if ({done, timeout, busy} !== 3'b100)
            $display("FAIL rst_relaunch_done: got done,to,busy=%b exp 100", {done, timeout, busy});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_stream();
        test_launch_zero();
        test_launch_single();
        test_launch_multi();
        test_timeout();
        test_fifo_backpressure();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
